// File: rtl/ap_cell_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ap_cell_pkg
// Purpose  : Shared opcodes, FSM states and per-cell select codes for the
//            cell_array_rc associative-processor cell array.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package ap_cell_pkg;

  // Command opcodes; encodings 9-15 are unused and behave as NOP.
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ROW_WR = 4'd1,
    OP_COL_WR = 4'd2,
    OP_COPY_B = 4'd3,
    OP_TAG_WB = 4'd4,
    OP_COPY_A = 4'd5,
    OP_ROW_RD = 4'd6,
    OP_COL_RD = 4'd7,
    OP_SCAN   = 4'd8
  } op_e;

  // Control FSM states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Source selected by a single cell on the current edge.
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_WR   = 3'd1,
    SEL_QA   = 3'd2,
    SEL_QB   = 3'd3,
    SEL_TAG  = 3'd4
  } sel_e;

  // Tag write-back inversion rule. Without abs_opt, passes 1 and 2 invert.
  // With abs_opt, only negative rows (q_s=1) invert, on passes 2 and 3.
  function automatic logic tag_invert(input logic abs_opt, input logic [2:0] pass,
                                      input logic q_s);
    logic inv;
    if (abs_opt) inv = q_s && ((pass == 3'd2) || (pass == 3'd3));
    else         inv = (pass == 3'd1) || (pass == 3'd2);
    return inv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_array_rc_cell_next.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cell_next
// Purpose  : Next-state selector for one bit cell of the array.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module cell_next
  import ap_cell_pkg::*;
(
  input  logic       cur_i,
  input  logic       qa_i,
  input  logic       qb_i,
  input  logic       wr_i,
  input  sel_e       sel_i,
  input  logic [2:0] pass_i,
  input  logic       abs_opt_i,
  input  logic       qs_i,
  output logic       next_o
);

  // Pick the cell's next value from the selected source; default is hold.
  always_comb begin
    next_o = cur_i;
    case (sel_i)
      SEL_WR:  next_o = wr_i;
      SEL_QA:  next_o = qa_i;
      SEL_QB:  next_o = qb_i;
      SEL_TAG: next_o = qa_i ^ tag_invert(abs_opt_i, pass_i, qs_i);
      default: next_o = cur_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cell_array_rc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cell_array_rc
// Purpose  : DATA_DEPTH x DATA_WIDTH bit-cell array with row/column write,
//            bulk copy, tagged write-back, row/column read and a full-array
//            row scan over a ready/valid read channel.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module cell_array_rc
  import ap_cell_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [3:0]                       cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_row_i,
  input  logic [DATA_DEPTH-1:0]            wr_col_i,
  input  logic [DATA_DEPTH-1:0]            tag_i,
  input  logic [DATA_WIDTH-1:0]            mask_i,
  input  logic [DATA_DEPTH-1:0]            q_s_i,
  input  logic                             abs_opt_i,
  input  logic [2:0]                       pass_i,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_a_i,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_b_i,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] q_o,
  output logic                             rd_valid_o,
  input  logic                             rd_ready_i,
  output logic [DATA_WIDTH-1:0]            rd_row_o,
  output logic [DATA_DEPTH-1:0]            rd_col_o,
  output logic [ADDR_WIDTH-1:0]            rd_idx_o,
  output logic                             err_o
);

  // One extra bit so the limits themselves are representable.
  localparam logic [ADDR_WIDTH:0]   c_depth_lim = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_width_lim = (ADDR_WIDTH+1)'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_row  = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_e                            state_q;
  logic [ADDR_WIDTH-1:0]             scan_cnt_q;
  logic [DATA_WIDTH*DATA_DEPTH-1:0]  array_q;
  logic [DATA_WIDTH*DATA_DEPTH-1:0]  array_d;
  logic                              rd_valid_q;
  logic [DATA_WIDTH-1:0]             rd_row_q;
  logic [DATA_DEPTH-1:0]             rd_col_q;
  logic [ADDR_WIDTH-1:0]             rd_idx_q;
  logic                              err_q;

  logic                              w_accept;
  logic                              w_addr_bad;
  logic                              w_exec;
  logic                              w_row_op;
  logic                              w_col_op;
  logic [ADDR_WIDTH-1:0]             w_rd_ridx;
  logic [DATA_WIDTH-1:0]             w_row_data;
  logic [DATA_DEPTH-1:0]             w_col_data;

  // A new command is taken only in IDLE with the read register free or draining.
  assign cmd_ready_o = rst && (state_q == ST_IDLE) && (!rd_valid_q || rd_ready_i);
  assign w_accept    = cmd_valid_i && cmd_ready_o;

  assign w_row_op   = (cmd_op_i == OP_ROW_WR) || (cmd_op_i == OP_ROW_RD);
  assign w_col_op   = (cmd_op_i == OP_COL_WR) || (cmd_op_i == OP_COL_RD);
  assign w_addr_bad = (w_row_op && ({1'b0, cmd_addr_i} >= c_depth_lim)) ||
                      (w_col_op && ({1'b0, cmd_addr_i} >= c_width_lim));
  assign w_exec     = w_accept && !w_addr_bad;

  // Row to fetch: next scan row while scanning, row 0 when a scan starts.
  always_comb begin
    w_rd_ridx = cmd_addr_i;
    if (state_q == ST_SCAN)          w_rd_ridx = scan_cnt_q + ADDR_WIDTH'(1);
    else if (cmd_op_i == OP_SCAN)    w_rd_ridx = '0;
  end

  // Row and column read multiplexers over the current (pre-write) array.
  always_comb begin
    w_row_data = '0;
    w_col_data = '0;
    for (int r = 0; r < DATA_DEPTH; r++) begin
      if (w_rd_ridx == ADDR_WIDTH'(r)) w_row_data = array_q[r*DATA_WIDTH +: DATA_WIDTH];
      for (int c = 0; c < DATA_WIDTH; c++) begin
        if (cmd_addr_i == ADDR_WIDTH'(c)) w_col_data[r] = array_q[r*DATA_WIDTH + c];
      end
    end
  end

  for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_row
    for (genvar gj = 0; gj < DATA_WIDTH; gj++) begin : g_col
      sel_e w_sel;
      logic w_wr;

      // Decode which source this cell takes for the accepted command.
      always_comb begin
        w_sel = SEL_HOLD;
        w_wr  = (cmd_op_i == OP_COL_WR) ? wr_col_i[gi] : wr_row_i[gj];
        if (w_exec) begin
          case (cmd_op_i)
            OP_ROW_WR: if (cmd_addr_i == ADDR_WIDTH'(gi)) w_sel = SEL_WR;
            OP_COL_WR: if (cmd_addr_i == ADDR_WIDTH'(gj)) w_sel = SEL_WR;
            OP_COPY_A: w_sel = SEL_QA;
            OP_COPY_B: w_sel = SEL_QB;
            OP_TAG_WB: if (tag_i[gi] && mask_i[gj]) w_sel = SEL_TAG;
            default:   w_sel = SEL_HOLD;
          endcase
        end
      end

      cell_next u_cell (
        .cur_i     (array_q[gi*DATA_WIDTH + gj]),
        .qa_i      (q_a_i[gi*DATA_WIDTH + gj]),
        .qb_i      (q_b_i[gi*DATA_WIDTH + gj]),
        .wr_i      (w_wr),
        .sel_i     (w_sel),
        .pass_i    (pass_i),
        .abs_opt_i (abs_opt_i),
        .qs_i      (q_s_i[gi]),
        .next_o    (array_d[gi*DATA_WIDTH + gj])
      );
    end
  end

  // Array storage; every cell reloads from its selector each edge.
  always_ff @(posedge clk) begin
    if (!rst) array_q <= '0;
    else      array_q <= array_d;
  end

  // Control FSM, read-result register and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      scan_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= w_accept && w_addr_bad;
      case (state_q)
        ST_IDLE: begin
          if (rd_valid_q && rd_ready_i) rd_valid_q <= 1'b0;
          if (w_exec) begin
            case (cmd_op_i)
              OP_ROW_RD: begin
                rd_valid_q <= 1'b1;
                rd_row_q   <= w_row_data;
                rd_col_q   <= '0;
                rd_idx_q   <= cmd_addr_i;
              end
              OP_COL_RD: begin
                rd_valid_q <= 1'b1;
                rd_row_q   <= '0;
                rd_col_q   <= w_col_data;
                rd_idx_q   <= cmd_addr_i;
              end
              OP_SCAN: begin
                rd_valid_q <= 1'b1;
                rd_row_q   <= w_row_data;
                rd_col_q   <= '0;
                rd_idx_q   <= '0;
                scan_cnt_q <= '0;
                state_q    <= ST_SCAN;
              end
              default: ;
            endcase
          end
        end
        ST_SCAN: begin
          if (rd_valid_q && rd_ready_i) begin
            if (scan_cnt_q == c_last_row) begin
              rd_valid_q <= 1'b0;
              scan_cnt_q <= '0;
              state_q    <= ST_IDLE;
            end else begin
              scan_cnt_q <= scan_cnt_q + ADDR_WIDTH'(1);
              rd_row_q   <= w_row_data;
              rd_idx_q   <= scan_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q_o        = array_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_row_o   = rd_row_q;
  assign rd_col_o   = rd_col_q;
  assign rd_idx_o   = rd_idx_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_array_rc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_cell_array_rc
// Purpose  : Directed vector bench for cell_array_rc (8x8, 4-bit address).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_cell_array_rc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  wr_row = '0, wr_col = '0, tag = '0, mask = '0, q_s = '0;
  logic        abs_opt = 1'b0;
  logic [2:0]  pass = '0;
  logic [63:0] q_a = '0, q_b = '0, q;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_row, rd_col;
  logic [3:0]  rd_idx;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  cell_array_rc #(.DATA_WIDTH(8), .DATA_DEPTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
    .wr_row_i(wr_row), .wr_col_i(wr_col),
    .tag_i(tag), .mask_i(mask), .q_s_i(q_s), .abs_opt_i(abs_opt), .pass_i(pass),
    .q_a_i(q_a), .q_b_i(q_b), .q_o(q),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_row_o(rd_row), .rd_col_o(rd_col), .rd_idx_o(rd_idx), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  addr;
    logic [7:0]  wrow, wcol, tag, mask, qs;
    logic        abs_opt;
    logic [2:0]  pass;
    logic [63:0] qa, qb, exp_q;
    logic        exp_rv;
    logic [7:0]  exp_row, exp_col;
    logic [3:0]  exp_idx;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [3:0] op, input logic [3:0] addr, input logic [7:0] wrow,
    input logic [7:0] wcol, input logic [7:0] tg, input logic [7:0] mk_mask,
    input logic [7:0] qs, input logic ab, input logic [2:0] ps,
    input logic [63:0] qa, input logic [63:0] qb, input logic [63:0] eq,
    input logic rv, input logic [7:0] er, input logic [7:0] ec,
    input logic [3:0] ei, input logic ee);
    vec_t v;
    v.op = op; v.addr = addr; v.wrow = wrow; v.wcol = wcol; v.tag = tg;
    v.mask = mk_mask; v.qs = qs; v.abs_opt = ab; v.pass = ps; v.qa = qa; v.qb = qb;
    v.exp_q = eq; v.exp_rv = rv; v.exp_row = er; v.exp_col = ec;
    v.exp_idx = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] Z    = 64'h0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT  = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [63:0] pat;
    int beat;
    pat = PAT;

    //           op addr wrow  wcol  tag   mask  qs  ab ps qa    qb    exp_q                  rv row   col   idx err
    vecs.push_back(mk(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0, Z, Z, 64'h00000000A5000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 3, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h00000000A5000000, 1, 8'hA5, 0, 3, 0));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h00000000A5000000, 1, 0, 8'h08, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, ONES, Z, Z, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 8'hFF, 0, 0, 0, 0, 0, Z, Z, 64'h0101010101010101, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h0101010101010101, 1, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 9, 8'hFF, 0, 0, 0, 0, 0, 0, Z, Z, 64'h0101010101010101, 0, 0, 0, 0, 1));
    vecs.push_back(mk(7, 8, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h0101010101010101, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONES, ONES, 64'h0101010101010101, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, ONES, Z, ONES, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h01, 8'h0F, 0, 0, 1, ONES, Z, 64'hFFFFFFFFFFFFFFF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h80, 8'hFF, 0, 0, 0, Z, Z, 64'h00FFFFFFFFFFFFF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h02, 8'h01, 0, 0, 2, ONES, Z, 64'h00FFFFFFFFFFFEF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h04, 8'h80, 0, 0, 3, Z, Z, 64'h00FFFFFFFF7FFEF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(13, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, ONES, ONES, 64'h00FFFFFFFF7FFEF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, ONES, Z, Z, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h03, 8'hFF, 8'h01, 1, 3, ONES, Z, 64'h000000000000FF00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h03, 8'hFF, 8'h01, 1, 4, ONES, Z, 64'h000000000000FFFF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h01, 8'h0F, 8'h01, 1, 2, ONES, Z, 64'h000000000000FFF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 8'h04, 8'h01, 8'hFF, 1, 1, ONES, Z, 64'h000000000001FFF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 1, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h000000000001FFF0, 1, 8'hFF, 0, 1, 0));
    vecs.push_back(mk(6, 2, 0, 0, 0, 0, 0, 0, 0, Z, Z, 64'h000000000001FFF0, 1, 8'h01, 0, 2, 0));
    vecs.push_back(mk(2, 8, 0, 8'hFF, 0, 0, 0, 0, 0, Z, Z, 64'h000000000001FFF0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 7, 0, 8'h81, 0, 0, 0, 0, 0, Z, Z, 64'h8000000000017FF0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, PAT, Z, PAT, 0, 0, 0, 0, 0));

    // Reset state, including cmd_ready held low while rst=0.
    tick(); tick();
    chk("reset q", q, Z);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset err", err, 0);
    chk("reset cmd_ready", cmd_ready, 0);
    rst = 1'b1;
    rd_ready = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      cmd_valid = 1'b1;
      cmd_op = vecs[k].op;   cmd_addr = vecs[k].addr;
      wr_row = vecs[k].wrow; wr_col = vecs[k].wcol;
      tag = vecs[k].tag;     mask = vecs[k].mask; q_s = vecs[k].qs;
      abs_opt = vecs[k].abs_opt; pass = vecs[k].pass;
      q_a = vecs[k].qa;      q_b = vecs[k].qb;
      #1;
      chk($sformatf("v%0d cmd_ready", k), cmd_ready, 1);
      tick();
      chk($sformatf("v%0d q", k), q, vecs[k].exp_q);
      chk($sformatf("v%0d rd_valid", k), rd_valid, vecs[k].exp_rv);
      chk($sformatf("v%0d err", k), err, vecs[k].exp_err);
      if (vecs[k].exp_rv) begin
        chk($sformatf("v%0d rd_row", k), rd_row, vecs[k].exp_row);
        chk($sformatf("v%0d rd_col", k), rd_col, vecs[k].exp_col);
        chk($sformatf("v%0d rd_idx", k), rd_idx, vecs[k].exp_idx);
      end
    end
    cmd_valid = 1'b0;

    // Full scan of the PAT array with rd_ready toggling 0/1.
    cmd_op = 4'd8; cmd_valid = 1'b1; rd_ready = 1'b0;
    #1;
    chk("scan cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    beat = 0;
    for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
      chk($sformatf("scan%0d rd_valid", beat), rd_valid, 1);
      chk($sformatf("scan%0d rd_idx", beat), rd_idx, beat);
      chk($sformatf("scan%0d rd_row", beat), rd_row, pat[beat*8 +: 8]);
      chk($sformatf("scan%0d rd_col", beat), rd_col, 0);
      chk($sformatf("scan%0d cmd_ready", beat), cmd_ready, 0);
      chk($sformatf("scan%0d q", beat), q, PAT);
      rd_ready = (cyc % 2) == 1;
      tick();
      if (rd_ready) beat++;
    end
    chk("scan beats", beat, 8);
    rd_ready = 1'b0;
    #1;
    chk("scan end rd_valid", rd_valid, 0);
    chk("scan end cmd_ready", cmd_ready, 1);

    // Stalled ROW_RD holds data; ready frees cmd_ready during the drain cycle.
    cmd_op = 4'd6; cmd_addr = 4'd7; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("stall rd_valid", rd_valid, 1);
    chk("stall rd_row", rd_row, 8'h01);
    chk("stall rd_idx", rd_idx, 7);
    chk("stall cmd_ready", cmd_ready, 0);
    tick();
    chk("stall hold rd_valid", rd_valid, 1);
    chk("stall hold rd_row", rd_row, 8'h01);
    rd_ready = 1'b1;
    #1;
    chk("drain cmd_ready", cmd_ready, 1);
    tick();
    chk("drain rd_valid", rd_valid, 0);

    // Reset in the middle of a scan discards the pending beat.
    cmd_op = 4'd8; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("midscan rd_idx", rd_idx, 1);
    chk("midscan rd_row", rd_row, 8'hCD);
    rst = 1'b0;
    #1;
    chk("midscan rst cmd_ready", cmd_ready, 0);
    tick();
    chk("midscan rst rd_valid", rd_valid, 0);
    chk("midscan rst q", q, Z);
    chk("midscan rst rd_row", rd_row, 0);
    chk("midscan rst rd_idx", rd_idx, 0);
    rst = 1'b1;
    #1;
    chk("post rst cmd_ready", cmd_ready, 1);
    cmd_op = 4'd6; cmd_addr = 4'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("post rst rd_valid", rd_valid, 1);
    chk("post rst rd_row", rd_row, 0);
    chk("post rst rd_idx", rd_idx, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
